// File: rtl/cla_arb_pkg.sv
// ============================================================================
// Module   : cla_arb_pkg
// Purpose  : Shared constants, the pipeline beat record and a small index
//            helper for the cla_arbiter block.
// Contents : DATA_W, PIPE_LAT, ID_MAX_W, beat_t, wrap_inc()
// Config   : none (CLA_ARB_LOCK_EN is consumed by cla_arbiter only)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_arb_pkg;

    localparam int DATA_W   = 32;
    localparam int PIPE_LAT = 2;
    // Widest requester index the block ever needs (NREQ <= 8).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic                ci;
        logic [ID_MAX_W-1:0] id;
    } beat_t;

    // Index + 1, wrapping to zero at n. Works for non-power-of-two n.
    function automatic logic [ID_MAX_W-1:0] wrap_inc(input logic [ID_MAX_W-1:0] idx,
                                                     input int                  n);
        int v;
        v = int'(idx) + 1;
        if (v >= n) begin
            v = 0;
        end
        return ID_MAX_W'(v);
    endfunction

endpackage : cla_arb_pkg

`default_nettype wire

// File: rtl/cla32.sv
// ============================================================================
// Module   : cla32
// Purpose  : 32-bit two-level carry-lookahead adder (purely combinational).
//            Eight 4-bit groups each produce group generate/propagate; the
//            group carries are resolved from those, then the in-group carries.
// Ports    : i_a, i_b [31:0]  operands
//            i_ci             carry-in
//            o_s [31:0]       sum
//            o_co             carry-out (bit 32 of a + b + ci)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_s,
    output logic        o_co
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_c;
    logic [7:0]  w_gg;
    logic [7:0]  w_gp;
    logic [8:0]  w_gc;

    always_comb begin
        w_g  = i_a & i_b;
        w_p  = i_a ^ i_b;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;

        for (int k = 0; k < 8; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end

        w_gc[0] = i_ci;
        for (int k = 0; k < 8; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end

        for (int k = 0; k < 8; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1]
                       | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2]
                       | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end

        o_s  = w_p ^ w_c;
        o_co = w_gc[8];
    end

endmodule : cla32

`default_nettype wire

// File: rtl/cla_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Searches upward from i_ptr
//            with wrap-around; the first asserted request wins. When
//            i_force_en is high only i_force_idx may win (and only if it is
//            requesting).
// Ports    : i_req [NREQ-1:0]     request vector
//            i_ptr [IDW-1:0]      highest-priority index
//            i_force_en           restrict the grant to i_force_idx
//            i_force_idx [IDW-1:0]
//            o_gnt [NREQ-1:0]     one-hot grant (or zero)
//            o_idx [IDW-1:0]      binary index of the grant
//            o_any                a grant was issued
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_force_en,
    input  logic [IDW-1:0]  i_force_idx,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int   d;
        logic found;

        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        d     = 0;

        if (i_force_en) begin
            o_idx = i_force_idx;
            for (int i = 0; i < NREQ; i++) begin
                if ((i == int'(i_force_idx)) && i_req[i]) begin
                    o_gnt[i] = 1'b1;
                end
            end
        end else begin
            // Rank each requester by its distance above the pointer and take
            // the nearest asserted one.
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    d = i - int'(i_ptr);
                    if (d < 0) begin
                        d = d + NREQ;
                    end
                    if (!found && i_req[i] && (d == k)) begin
                        found    = 1'b1;
                        o_gnt[i] = 1'b1;
                        o_idx    = IDW'(i);
                    end
                end
            end
        end

        o_any = |o_gnt;
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/cla_arbiter.sv
// ============================================================================
// Module   : cla_arbiter
// Purpose  : Round-robin arbiter sharing one registered cla32 adder among
//            NREQ requesters. One beat per cycle enters a two-stage pipeline
//            (input register -> cla32 -> output register); every accepted
//            beat returns a one-cycle rsp_valid pulse two cycles later, tagged
//            with the owning requester index.
// Ports    : clk, reset                 clock, synchronous active-high reset
//            req_valid/req_ready [NREQ] per-requester handshake
//            req_a/req_b [NREQ*32]      packed operands, requester i at [32i+:32]
//            req_ci [NREQ]              carry-in
//            req_lock [NREQ]            chain request (lock build only)
//            rsp_valid, rsp_id, rsp_s, rsp_co  registered result
// Config   : CLA_ARB_LOCK_EN - when defined, a lock beat pins the grant to
//            its requester and later beats of the chain take the previous
//            beat's carry-out instead of req_ci.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_ci,
    input  logic [NREQ-1:0]        req_lock,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_s,
    output logic                   rsp_co
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]    ptr_q,       ptr_d;
    logic              s1_valid_q,  s1_valid_d;
    beat_t             s1_q,        s1_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_s_q,     rsp_s_d;
    logic              rsp_co_q,    rsp_co_d;
    logic [IDW-1:0]    rsp_id_q,    rsp_id_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [NREQ-1:0]   w_gnt;
    logic [IDW-1:0]    w_win_idx;
    logic              w_any;
    logic              w_xfer;
    logic              w_force_en;
    logic [IDW-1:0]    w_force_idx;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic              w_sel_ci;
    logic              w_sel_lock;
    logic              w_beat_ci;
    logic [DATA_W-1:0] w_sum;
    logic              w_co;
    logic              w_unused;

`ifdef CLA_ARB_LOCK_EN
    logic              lock_q,       lock_d;
    logic [IDW-1:0]    lock_idx_q,   lock_idx_d;
    logic              carry_hold_q, carry_hold_d;
    logic              w_chain_ci;

    assign w_force_en  = lock_q;
    assign w_force_idx = lock_idx_q;

    // While a beat sits in stage 1 its carry-out is still combinational;
    // after a bubble the last carry-out has been parked in carry_hold.
    assign w_chain_ci  = s1_valid_q ? w_co : carry_hold_q;
    assign w_beat_ci   = lock_q ? w_chain_ci : w_sel_ci;
    assign w_unused    = ^s1_q.id;
`else
    assign w_force_en  = 1'b0;
    assign w_force_idx = '0;
    assign w_beat_ci   = w_sel_ci;
    assign w_unused    = (^s1_q.id) ^ w_sel_lock;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req       (req_valid),
        .i_ptr       (ptr_q),
        .i_force_en  (w_force_en),
        .i_force_idx (w_force_idx),
        .o_gnt       (w_gnt),
        .o_idx       (w_win_idx),
        .o_any       (w_any)
    );

    // Ready is suppressed for the whole reset cycle.
    assign req_ready = reset ? '0 : w_gnt;
    assign w_xfer    = w_any & ~reset;

    // One-hot operand mux driven by the grant.
    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ci   = 1'b0;
        w_sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a    = req_a[i*DATA_W +: DATA_W];
                w_sel_b    = req_b[i*DATA_W +: DATA_W];
                w_sel_ci   = req_ci[i];
                w_sel_lock = req_lock[i];
            end
        end
    end

    cla32 u_add (
        .i_a  (s1_q.a),
        .i_b  (s1_q.b),
        .i_ci (s1_q.ci),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = w_xfer;
        s1_d        = s1_q;
        rsp_valid_d = s1_valid_q;
        rsp_s_d     = rsp_s_q;
        rsp_co_d    = rsp_co_q;
        rsp_id_d    = rsp_id_q;

        if (w_xfer) begin
            ptr_d   = IDW'(wrap_inc(ID_MAX_W'(w_win_idx), NREQ));
            s1_d.a  = w_sel_a;
            s1_d.b  = w_sel_b;
            s1_d.ci = w_beat_ci;
            s1_d.id = ID_MAX_W'(w_win_idx);
        end

        // Result registers only move on a real beat so idle cycles hold.
        if (s1_valid_q) begin
            rsp_s_d  = w_sum;
            rsp_co_d = w_co;
            rsp_id_d = s1_q.id[IDW-1:0];
        end
    end

`ifdef CLA_ARB_LOCK_EN
    always_comb begin
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        carry_hold_d = s1_valid_q ? w_co : carry_hold_q;
        // Every transfer re-decides the lock: lock=1 starts/continues the
        // chain, lock=0 is the closing beat.
        if (w_xfer) begin
            lock_d     = w_sel_lock;
            lock_idx_d = w_win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            carry_hold_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            carry_hold_q <= carry_hold_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_s_q     <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_s_q     <= rsp_s_d;
            rsp_co_q    <= rsp_co_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_id    = rsp_id_q;

endmodule : cla_arbiter

`default_nettype wire
